// File: rtl/rtype_fetch_ctrl.sv
// rtype_fetch_ctrl: multi-cycle fetch/decode/execute sequencer for RV32I R-type
// instructions. It holds a PC and a small loadable instruction memory, and drives
// the register-file/ALU datapath. Each instruction takes three cycles:
// FETCH, DECODE and EXEC. Any encoding outside the supported R-type set stops the
// sequencer in HALT until reset. An all-zero word acts as the program terminator.
module rtype_fetch_ctrl #(
  parameter int IMEM_DEPTH = 32,
  parameter int AW         = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             imem_we,
  input  logic [AW-1:0]    imem_addr,
  input  logic [31:0]      imem_wdata,
  output logic [4:0]       read_reg_num1,
  output logic [4:0]       read_reg_num2,
  output logic [4:0]       write_reg,
  output logic [3:0]       alu_control,
  output logic             regwrite,
  output logic [31:0]      pc,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]   imem [IMEM_DEPTH];
  logic [31:0]   instr_reg;

  // Fields of the latched instruction
  logic [6:0]    opcode;
  logic [4:0]    rd_f;
  logic [2:0]    funct3;
  logic [4:0]    rs1_f;
  logic [4:0]    rs2_f;
  logic [6:0]    funct7;

  logic [4:0]    dec_word;
  logic          dec_legal;
  logic [3:0]    dec_alu;

  logic [AW-1:0] pc_idx;
  logic [AW-1:0] pc_idx_inc;
  logic [31:0]   pc_inc;
  logic          mem_wr_ok;

  // Maps funct7/funct3 to {legal, alu_control}; anything not listed is illegal.
  function automatic logic [4:0] alu_decode(input logic [6:0] f7, input logic [2:0] f3);
    logic [4:0] r;
    r = 5'b0_0000;
    case ({f7, f3})
      {7'h00, 3'b000}: r = 5'b1_0010; // ADD
      {7'h20, 3'b000}: r = 5'b1_0110; // SUB
      {7'h00, 3'b111}: r = 5'b1_0000; // AND
      {7'h00, 3'b110}: r = 5'b1_0001; // OR
      {7'h00, 3'b100}: r = 5'b1_0011; // XOR
      {7'h00, 3'b001}: r = 5'b1_0100; // SLL
      {7'h00, 3'b101}: r = 5'b1_0101; // SRL
      {7'h00, 3'b010}: r = 5'b1_0111; // SLT
      {7'h00, 3'b011}: r = 5'b1_1000; // SLTU
      default:         r = 5'b0_0000;
    endcase
    return r;
  endfunction

  assign opcode = instr_reg[6:0];
  assign rd_f   = instr_reg[11:7];
  assign funct3 = instr_reg[14:12];
  assign rs1_f  = instr_reg[19:15];
  assign rs2_f  = instr_reg[24:20];
  assign funct7 = instr_reg[31:25];

  assign dec_word  = alu_decode(funct7, funct3);
  assign dec_legal = (opcode == OPC_RTYPE) && dec_word[4];
  assign dec_alu   = dec_word[3:0];

  // PC only ever holds word-aligned addresses inside the memory, so the
  // increment happens on the word index and wraps naturally at the top.
  assign pc_idx     = pc[AW+1:2];
  assign pc_idx_inc = pc_idx + AW'(1);
  assign pc_inc     = {{(30-AW){1'b0}}, pc_idx_inc, 2'b00};

  // The program can only be changed while the sequencer is not executing.
  assign mem_wr_ok = imem_we && ((state == S_IDLE) || (state == S_HALT));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = dec_legal ? S_EXEC : S_HALT;
      S_EXEC:   state_next = run ? S_FETCH : S_IDLE;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  // Instruction memory write port; contents survive reset
  always_ff @(posedge clock) begin
    if (mem_wr_ok) begin
      imem[imem_addr] <= imem_wdata;
    end
  end

  // ---- stage boundary: FETCH -> DECODE (synchronous memory read) ----
  // Instruction register, loaded from memory at the current PC during FETCH
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_reg <= '0;
    end else if (state == S_FETCH) begin
      instr_reg <= imem[pc_idx];
    end
  end

  // ---- stage boundary: DECODE -> EXEC -> retire ----
  // Registered datapath controls, PC, retire counter and halt flag
  always_ff @(posedge clock) begin
    if (reset) begin
      read_reg_num1 <= '0;
      read_reg_num2 <= '0;
      write_reg     <= '0;
      alu_control   <= '0;
      regwrite      <= 1'b0;
      pc            <= '0;
      retired       <= '0;
      halted        <= 1'b0;
    end else begin
      // The write strobe lives for the single EXEC cycle only.
      regwrite <= 1'b0;
      halted   <= (state_next == S_HALT);
      case (state)
        S_DECODE: begin
          // Illegal words leave the previous register numbers in place.
          if (dec_legal) begin
            read_reg_num1 <= rs1_f;
            read_reg_num2 <= rs2_f;
            write_reg     <= rd_f;
            alu_control   <= dec_alu;
            regwrite      <= (rd_f != 5'd0);
          end
        end
        S_EXEC: begin
          pc      <= pc_inc;
          retired <= retired + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_fetch_ctrl.sv
// Bench for rtype_fetch_ctrl: table of single-instruction programs plus
// hand-written sequences for multi-instruction and reset/run corner cases.
module tb_rtype_fetch_ctrl;

  localparam int IMEM_DEPTH = 32;
  localparam int AW         = 5;
  localparam int CNT_W      = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             run = 1'b0;
  logic             imem_we = 1'b0;
  logic [AW-1:0]    imem_addr = '0;
  logic [31:0]      imem_wdata = '0;
  logic [4:0]       read_reg_num1;
  logic [4:0]       read_reg_num2;
  logic [4:0]       write_reg;
  logic [3:0]       alu_control;
  logic             regwrite;
  logic [31:0]      pc;
  logic             halted;
  logic [CNT_W-1:0] retired;

  int tests = 0;
  int fails = 0;

  rtype_fetch_ctrl #(.IMEM_DEPTH(IMEM_DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .run(run), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
    .pc(pc), .halted(halted), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        legal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        rw;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    imem_we    = 1'b1;
    imem_addr  = a;
    imem_wdata = d;
    tick();
    imem_we    = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"add",    32'h002081B3,                  1'b1, 5'd1,  5'd2,  5'd3,  4'b0010, 1'b1};
    vecs[1]  = '{"sub",    32'h40118233,                  1'b1, 5'd3,  5'd1,  5'd4,  4'b0110, 1'b1};
    vecs[2]  = '{"and",    enc(7'h00, 5'd7,  5'd6,  3'b111, 5'd5),  1'b1, 5'd6,  5'd7,  5'd5,  4'b0000, 1'b1};
    vecs[3]  = '{"or",     enc(7'h00, 5'd10, 5'd9,  3'b110, 5'd8),  1'b1, 5'd9,  5'd10, 5'd8,  4'b0001, 1'b1};
    vecs[4]  = '{"xor",    enc(7'h00, 5'd13, 5'd12, 3'b100, 5'd11), 1'b1, 5'd12, 5'd13, 5'd11, 4'b0011, 1'b1};
    vecs[5]  = '{"sll",    enc(7'h00, 5'd16, 5'd15, 3'b001, 5'd14), 1'b1, 5'd15, 5'd16, 5'd14, 4'b0100, 1'b1};
    vecs[6]  = '{"srl",    enc(7'h00, 5'd19, 5'd18, 3'b101, 5'd17), 1'b1, 5'd18, 5'd19, 5'd17, 4'b0101, 1'b1};
    vecs[7]  = '{"slt",    enc(7'h00, 5'd22, 5'd21, 3'b010, 5'd20), 1'b1, 5'd21, 5'd22, 5'd20, 4'b0111, 1'b1};
    vecs[8]  = '{"sltu",   enc(7'h00, 5'd29, 5'd30, 3'b011, 5'd31), 1'b1, 5'd30, 5'd29, 5'd31, 4'b1000, 1'b1};
    vecs[9]  = '{"add_x0", 32'h00208033,                  1'b1, 5'd1,  5'd2,  5'd0,  4'b0010, 1'b0};
    vecs[10] = '{"addi",   32'h00000013,                  1'b0, 5'd0,  5'd0,  5'd0,  4'b0000, 1'b0};
    vecs[11] = '{"zero",   32'h00000000,                  1'b0, 5'd0,  5'd0,  5'd0,  4'b0000, 1'b0};
    vecs[12] = '{"sra",    enc(7'h20, 5'd2,  5'd1,  3'b101, 5'd3),  1'b0, 5'd0,  5'd0,  5'd0,  4'b0000, 1'b0};
    vecs[13] = '{"mul",    enc(7'h01, 5'd2,  5'd1,  3'b000, 5'd3),  1'b0, 5'd0,  5'd0,  5'd0,  4'b0000, 1'b0};
    vecs[14] = '{"badopc", 32'h00208037,                  1'b0, 5'd0,  5'd0,  5'd0,  4'b0000, 1'b0};

    // Reset state
    reset = 1'b1;
    run   = 1'b1;
    tick();
    tick();
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fields", {15'd0, read_reg_num1, read_reg_num2, write_reg, alu_control}, 32'd0);
    reset = 1'b0;
    run   = 1'b0;

    // Table: one instruction followed by the terminator
    for (int i = 0; i < 15; i++) begin
      do_reset();
      load(5'd0, vecs[i].instr);
      load(5'd1, 32'h0);
      run = 1'b1;
      tick(); tick(); tick();
      if (vecs[i].legal) begin
        chk({vecs[i].name, "_rs1"}, 32'(read_reg_num1), 32'(vecs[i].rs1));
        chk({vecs[i].name, "_rs2"}, 32'(read_reg_num2), 32'(vecs[i].rs2));
        chk({vecs[i].name, "_rd"},  32'(write_reg),     32'(vecs[i].rd));
        chk({vecs[i].name, "_alu"}, 32'(alu_control),   32'(vecs[i].alu));
        chk({vecs[i].name, "_rw"},  32'(regwrite),      32'(vecs[i].rw));
        chk({vecs[i].name, "_nohalt"}, 32'(halted), 32'd0);
        tick();
        chk({vecs[i].name, "_rw_clr"}, 32'(regwrite), 32'd0);
        chk({vecs[i].name, "_pc4"}, pc, 32'd4);
        chk({vecs[i].name, "_ret1"}, 32'(retired), 32'd1);
        tick(); tick();
        chk({vecs[i].name, "_term_halt"}, 32'(halted), 32'd1);
        chk({vecs[i].name, "_term_pc"}, pc, 32'd4);
        chk({vecs[i].name, "_term_rw"}, 32'(regwrite), 32'd0);
      end else begin
        chk({vecs[i].name, "_halt"}, 32'(halted), 32'd1);
        chk({vecs[i].name, "_rw"}, 32'(regwrite), 32'd0);
        chk({vecs[i].name, "_pc"}, pc, 32'd0);
        chk({vecs[i].name, "_ret"}, 32'(retired), 32'd0);
        chk({vecs[i].name, "_fields"},
            {15'd0, read_reg_num1, read_reg_num2, write_reg, alu_control}, 32'd0);
      end
      run = 1'b0;
    end

    // rd=0 does not write, the next instruction does; both retire
    do_reset();
    load(5'd0, 32'h00208033);
    load(5'd1, 32'h002081B3);
    load(5'd2, 32'h0);
    run = 1'b1;
    tick(); tick(); tick();
    chk("seq3_rw0", 32'(regwrite), 32'd0);
    tick(); tick(); tick();
    chk("seq3_rw1", 32'(regwrite), 32'd1);
    chk("seq3_rd", 32'(write_reg), 32'd3);
    tick();
    chk("seq3_ret", 32'(retired), 32'd2);
    tick(); tick();
    chk("seq3_halt", 32'(halted), 32'd1);
    chk("seq3_pc", pc, 32'd8);
    chk("seq3_ret_halt", 32'(retired), 32'd2);

    // HALT is sticky regardless of run; only reset leaves it
    do_reset();
    load(5'd0, 32'h00000013);
    run = 1'b1;
    tick(); tick(); tick();
    run = 1'b0; tick(); tick();
    run = 1'b1; tick(); tick();
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_sticky_pc", pc, 32'd0);
    chk("halt_sticky_rw", 32'(regwrite), 32'd0);
    reset = 1'b1; tick(); reset = 1'b0; run = 1'b0;
    chk("halt_reset", 32'(halted), 32'd0);
    tick();
    chk("halt_reset_idle", 32'(halted), 32'd0);

    // Full memory of adds: PC wraps, execution continues, busy writes ignored
    do_reset();
    for (int a = 0; a < IMEM_DEPTH; a++) load(AW'(a), 32'h002081B3);
    run = 1'b1;
    repeat (97) tick();
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_ret", 32'(retired), 32'd32);
    imem_we = 1'b1; imem_addr = 5'd0; imem_wdata = 32'h0;
    tick(); tick();
    chk("wrap_cont_rw", 32'(regwrite), 32'd1);
    tick();
    imem_we = 1'b0;
    chk("wrap_pc4", pc, 32'd4);
    chk("wrap_ret33", 32'(retired), 32'd33);
    run = 1'b0;
    tick(); tick(); tick();
    chk("wrap_idle_pc", pc, 32'd8);
    chk("wrap_idle_ret", 32'(retired), 32'd34);
    do_reset();
    run = 1'b1;
    tick(); tick(); tick();
    chk("busy_we_ignored_halt", 32'(halted), 32'd0);
    chk("busy_we_ignored_rw", 32'(regwrite), 32'd1);

    // Reset in the middle of EXEC
    do_reset();
    run = 1'b1;
    tick(); tick(); tick();
    chk("exec_rw_before_rst", 32'(regwrite), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0; run = 1'b0;
    chk("exec_rst_rw", 32'(regwrite), 32'd0);
    chk("exec_rst_pc", pc, 32'd0);
    chk("exec_rst_ret", 32'(retired), 32'd0);
    chk("exec_rst_rs1", 32'(read_reg_num1), 32'd0);
    tick(); tick();
    chk("exec_rst_idle_pc", pc, 32'd0);
    chk("exec_rst_idle_rw", 32'(regwrite), 32'd0);

    // run dropped during DECODE: instruction completes, then IDLE
    run = 1'b1;
    tick(); tick();
    run = 1'b0;
    tick();
    chk("runlow_rw", 32'(regwrite), 32'd1);
    tick();
    chk("runlow_pc", pc, 32'd4);
    chk("runlow_ret", 32'(retired), 32'd1);
    tick(); tick(); tick();
    chk("runlow_idle_pc", pc, 32'd4);
    chk("runlow_idle_ret", 32'(retired), 32'd1);
    chk("runlow_idle_rw", 32'(regwrite), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtype_fetch_ctrl.md
Name: rtype_fetch_ctrl

Overview:
Multi-cycle instruction fetch and control stage that sits directly upstream of the register-file/ALU datapath. It holds a PC and a small loadable instruction memory, fetches RV32I R-type instructions, and decodes them. It drives the datapath's read_reg_num1, read_reg_num2, write_reg, alu_control and regwrite inputs with a 3-cycle-per-instruction FSM. Any non-R-type or unsupported encoding halts the sequencer.

Parameters:
IMEM_DEPTH, 32, number of 32-bit instruction words; a power of 2.
AW, 5, word-address width, equal to log2(IMEM_DEPTH).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
run  in  1  level; when high, the sequencer leaves IDLE and keeps executing.
imem_we  in  1  instruction-memory write enable; honoured only in IDLE or HALT.
imem_addr  in  AW  instruction-memory word address for writes.
imem_wdata  in  32  instruction word to write.
read_reg_num1  out  5  rs1 field, i.e. instr[19:15].
read_reg_num2  out  5  rs2 field, i.e. instr[24:20].
write_reg  out  5  rd field, i.e. instr[11:7].
alu_control  out  4  ALU operation code.
regwrite  out  1  register-file write strobe.
pc  out  32  byte address of the current instruction.
halted  out  1  high in the HALT state.
retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset: synchronous, active-high. On any rising edge with reset=1, the block sets:
  - state=IDLE, pc=0, instr_reg=0, retired=0, halted=0, regwrite=0;
  - read_reg_num1, read_reg_num2, write_reg and alu_control all to 0.
  - Memory contents are not cleared.
  - Reset overrides run, imem_we and every state, including the middle of EXEC: regwrite is 0 from the first cycle after the reset edge.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT. All outputs are registered.
- IDLE:
  - Accepts imem writes.
  - If run=1, goes to FETCH; otherwise stays.
- FETCH: instr_reg <= imem[pc[AW+1:2]] (synchronous read), then goes to DECODE.
- DECODE, legality check:
  - Legal means opcode instr[6:0]=0110011 and (funct7, funct3) is one of the table entries below.
  - If legal: load read_reg_num1, read_reg_num2, write_reg and alu_control from the fields, and go to EXEC.
  - If illegal: go to HALT, with the register numbers and alu_control unchanged.
- alu_control map, listed as funct7/funct3 -> code:
  - 0x00/000 ADD -> 0010
  - 0x20/000 SUB -> 0110
  - 0x00/111 AND -> 0000
  - 0x00/110 OR -> 0001
  - 0x00/100 XOR -> 0011
  - 0x00/001 SLL -> 0100
  - 0x00/101 SRL -> 0101
  - 0x00/010 SLT -> 0111
  - 0x00/011 SLTU -> 1000
  - Any other funct7 is illegal.
- regwrite is set on the DECODE->EXEC edge, only if rd!=0, and cleared on the EXEC exit edge. It is therefore high for exactly one EXEC cycle, and never high in any other state.
- EXEC exit edge:
  - pc <= pc+4, wrapping to 0 after byte address 4*IDEPTH-4 (IDEPTH = IMEM_DEPTH).
  - retired <= retired+1, wrapping modulo 2^CNT_W. This also counts instructions with rd=0.
  - Next state is FETCH if run=1, else IDLE.
- Latency: 3 cycles per instruction, and the datapath write occurs at the end of EXEC.
- Register numbers and alu_control stay stable from EXEC entry until the next legal DECODE.
- run low mid-instruction: the current instruction completes; the sequencer returns to IDLE after EXEC with pc already advanced.
- HALT:
  - halted=1 and regwrite=0; pc points at the offending instruction.
  - Stays in HALT regardless of run; only reset leaves it.
  - imem writes are accepted.
- An all-zero word is illegal and serves as the program terminator.
- imem_we in FETCH, DECODE or EXEC is ignored: the memory is unchanged.

Test Plan:
1. Load word0=0x002081B3 (add x3,x1,x2), word1=0x00000000; reset, then run=1 -> FETCH/DECODE/EXEC, and in EXEC: rs1=1, rs2=2, rd=3, alu_control=0010, regwrite=1 for exactly one cycle; next FETCH sees pc=4, retired=1. Then HALT with halted=1, pc=4.
2. Load word0=0x40118233 (sub x4,x3,x1) -> in EXEC: rs1=3, rs2=1, rd=4, alu_control=0110, regwrite=1.
3. Load word0=0x00208033 (add x0,x1,x2), word1=0x002081B3 -> regwrite stays 0 in the first EXEC and goes to 1 in the second; retired=2 before the terminator halts.
4. Load word0=0x00000013 (addi) -> HALT after DECODE; regwrite is never 1, retired=0, pc=0. Toggling run keeps halted=1, and reset returns to IDLE with halted=0.
5. Fill all 32 words with 0x002081B3 and hold run=1 -> after 32 instructions pc wraps to 0 and retired=32; execution continues. An imem_we pulse during EXEC does not alter memory (read it back after a reset).
6. Assert reset in the EXEC cycle of instruction 1 -> next cycle shows regwrite=0, pc=0, retired=0 and state IDLE; deassert run at DECODE instead -> the instruction completes, then IDLE with pc=4.
